// File: rtl/chs_pkg.sv
// Shared types and constants for the heat/cool actuator controller.
package chs_pkg;

    localparam int CHS_PWR_W   = 4;
    localparam int CHS_MAX_PWR = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        DRAIN = 2'd2,
        DEAD  = 2'd3
    } chs_state_e;

endpackage

// File: rtl/chs_pwm_gen.sv
// PWM generator: free-running period counter compared against duty, registered output.
module chs_pwm_gen
    import chs_pkg::*;
#(
    parameter int PWR_W   = CHS_PWR_W,
    parameter int MAX_PWR = CHS_MAX_PWR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWR_W-1:0] duty,
    input  logic             force_off,
    output logic             pwm
);

    localparam logic [PWR_W-1:0] LAST = PWR_W'(MAX_PWR - 1);

    logic [PWR_W-1:0] pwm_cnt_q;
    logic             pwm_q;

    // Period counter wraps at MAX_PWR-1; duty==MAX_PWR keeps output high every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= (pwm_cnt_q == LAST) ? '0 : pwm_cnt_q + 1'b1;
            pwm_q     <= (pwm_cnt_q < duty) && !force_off;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/chs_actuator_ctrl.sv
// Heater/cooler drive: registers the requested power/mode, slew-limits the
// applied power one step per ramp tick, and drains plus dead-times on a mode swap.
module chs_actuator_ctrl
    import chs_pkg::*;
#(
    parameter int PWR_W    = CHS_PWR_W,
    parameter int MAX_PWR  = CHS_MAX_PWR,
    parameter int RAMP_DIV = 16,
    parameter int DEAD_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PWR_W-1:0] chs_power,
    input  logic             chs_mode,
    input  logic             en,
    output logic             heat_on,
    output logic             cool_on,
    output logic [PWR_W-1:0] applied_power,
    output logic             applied_mode,
    output logic             busy,
    output logic             power_clamped
);

    localparam int TW = $clog2(RAMP_DIV);
    localparam int DW = $clog2(DEAD_CYC + 1);
    localparam logic [PWR_W-1:0] MAX_P    = PWR_W'(MAX_PWR);
    localparam logic [TW-1:0]    TICK_END = TW'(RAMP_DIV - 1);
    localparam logic [DW-1:0]    DEAD_END = DW'(DEAD_CYC - 1);

    logic [PWR_W-1:0] tgt_pwr_q;
    logic             tgt_mode_q;
    logic             power_clamped_q;
    logic [TW-1:0]    tick_cnt_q;
    logic             tick;

    chs_state_e       state_q, state_d;
    logic [PWR_W-1:0] applied_power_q, applied_power_d;
    logic             applied_mode_q, applied_mode_d;
    logic [DW-1:0]    dead_cnt_q, dead_cnt_d;
    logic             pwm;

    assign tick = (tick_cnt_q == TICK_END);

    // Input stage: clamp and gate the request; also the free-running ramp divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_pwr_q       <= '0;
            tgt_mode_q      <= 1'b0;
            power_clamped_q <= 1'b0;
            tick_cnt_q      <= '0;
        end else begin
            tgt_pwr_q       <= !en ? '0 : ((chs_power > MAX_P) ? MAX_P : chs_power);
            tgt_mode_q      <= chs_mode;
            power_clamped_q <= (chs_power > MAX_P);
            tick_cnt_q      <= tick ? '0 : tick_cnt_q + 1'b1;
        end
    end

    // FSM state and applied power/mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            applied_power_q <= '0;
            applied_mode_q  <= 1'b0;
            dead_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            applied_power_q <= applied_power_d;
            applied_mode_q  <= applied_mode_d;
            dead_cnt_q      <= dead_cnt_d;
        end
    end

    // Next-state logic: mode mismatch always drains first; power never jumps more than one step.
    always_comb begin
        state_d         = state_q;
        applied_power_d = applied_power_q;
        applied_mode_d  = applied_mode_q;
        dead_cnt_d      = dead_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (tgt_pwr_q != '0) begin
                    if (tgt_mode_q == applied_mode_q) begin
                        state_d = RAMP;
                    end else begin
                        state_d    = DEAD;
                        dead_cnt_d = '0;
                    end
                end
            end
            RAMP: begin
                if (tgt_mode_q != applied_mode_q) begin
                    state_d = DRAIN;
                end else if (applied_power_q == '0 && tgt_pwr_q == '0) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (applied_power_q < tgt_pwr_q) begin
                        applied_power_d = applied_power_q + 1'b1;
                    end else if (applied_power_q > tgt_pwr_q) begin
                        applied_power_d = applied_power_q - 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (tgt_mode_q == applied_mode_q) begin
                    state_d = RAMP;
                end else if (applied_power_q == '0) begin
                    state_d    = DEAD;
                    dead_cnt_d = '0;
                end else if (tick) begin
                    applied_power_d = applied_power_q - 1'b1;
                end
            end
            DEAD: begin
                // Mode is sampled only on exit; changes during dead time do not restart it.
                if (dead_cnt_q == DEAD_END) begin
                    applied_mode_d = tgt_mode_q;
                    state_d        = IDLE;
                end else begin
                    dead_cnt_d = dead_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    chs_pwm_gen #(
        .PWR_W   (PWR_W),
        .MAX_PWR (MAX_PWR)
    ) u_pwm (
        .clk       (clk),
        .rst_n     (rst_n),
        .duty      (applied_power_q),
        .force_off (state_q == DEAD),
        .pwm       (pwm)
    );

    // Steering one PWM stream by a single mode bit makes heat and cool mutually exclusive.
    assign heat_on       = pwm & applied_mode_q;
    assign cool_on       = pwm & ~applied_mode_q;
    assign applied_power = applied_power_q;
    assign applied_mode  = applied_mode_q;
    assign busy          = (state_q != IDLE) || (applied_power_q != tgt_pwr_q);
    assign power_clamped = power_clamped_q;

endmodule
